ov5640_pwr_seq: RTL

- Bidirectional OV5640 power sequencer.
- Power-up follows the sensor datasheet order: PWDN deassert, then RESETB release, then settle. It then runs the reverse power-down order: quiesce the SCCB bus, assert RESETB, assert PWDN, then enforce a minimum off time.
- Sits between the system power manager (`pwr_req`) and the camera pins. The SCCB configuration master consumes `pwr_on` and reports `bus_busy`.

---
 rtl/ov5640_pkg.sv | 21 ++
 rtl/ov5640_pwr_seq.sv | 124 ++++++++++++
 2 files changed

// File: rtl/ov5640_pkg.sv
// Shared OV5640 power-sequencing definitions: state encoding and default timing.
package ov5640_pkg;

  localparam int unsigned DEF_CNT_W     = 21;
  localparam int unsigned DEF_T_PWDN_UP = 300000;
  localparam int unsigned DEF_T_RST     = 100000;
  localparam int unsigned DEF_T_SETTLE  = 1050000;
  localparam int unsigned DEF_T_RST_DN  = 50000;
  localparam int unsigned DEF_T_OFF     = 500000;

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_UP_PWDN   = 3'd1,
    S_UP_RST    = 3'd2,
    S_UP_SETTLE = 3'd3,
    S_ON        = 3'd4,
    S_DN_WAIT   = 3'd5,
    S_DN_RST    = 3'd6
  } pwr_state_e;

endpackage

// File: rtl/ov5640_pwr_seq.sv
// OV5640 power sequencer: ordered PWDN/RESETB power-up and committed power-down
// with SCCB quiesce and minimum off time. All pin outputs are registered.
module ov5640_pwr_seq
  import ov5640_pkg::*;
#(
  parameter int unsigned T_PWDN_UP = DEF_T_PWDN_UP,
  parameter int unsigned T_RST     = DEF_T_RST,
  parameter int unsigned T_SETTLE  = DEF_T_SETTLE,
  parameter int unsigned T_RST_DN  = DEF_T_RST_DN,
  parameter int unsigned T_OFF     = DEF_T_OFF,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwr_req,
  input  logic bus_busy,
  output logic ov5640_pwdn,
  output logic ov5640_rst_n,
  output logic pwr_on,
  output logic pwr_off
);

  // Terminal counter values; timed states exit one cycle after reaching them.
  localparam logic [CNT_W-1:0] TC_OFF     = CNT_W'(T_OFF);
  localparam logic [CNT_W-1:0] TC_PWDN_UP = CNT_W'(T_PWDN_UP - 1);
  localparam logic [CNT_W-1:0] TC_RST     = CNT_W'(T_RST - 1);
  localparam logic [CNT_W-1:0] TC_SETTLE  = CNT_W'(T_SETTLE - 1);
  localparam logic [CNT_W-1:0] TC_RST_DN  = CNT_W'(T_RST_DN - 1);

  pwr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_term;
  logic             pwdn_d, rstb_d, pwr_on_d, pwr_off_d;

  // State and pin register; reset treats the off time as already met.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_OFF;
      cnt_q        <= TC_OFF;
      ov5640_pwdn  <= 1'b1;
      ov5640_rst_n <= 1'b0;
      pwr_on       <= 1'b0;
      pwr_off      <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ov5640_pwdn  <= pwdn_d;
      ov5640_rst_n <= rstb_d;
      pwr_on       <= pwr_on_d;
      pwr_off      <= pwr_off_d;
    end
  end

  // Next-state, shared counter and pin decode from the next state.
  always_comb begin
    state_d   = state_q;
    cnt_term  = '0;
    cnt_d     = cnt_q;
    pwdn_d    = 1'b1;
    rstb_d    = 1'b0;
    pwr_on_d  = 1'b0;
    pwr_off_d = 1'b0;

    // Aborts are tested before the timer so they win on a coincident cycle.
    case (state_q)
      S_OFF: begin
        cnt_term = TC_OFF;
        if ((cnt_q == TC_OFF) && pwr_req) state_d = S_UP_PWDN;
      end
      S_UP_PWDN: begin
        cnt_term = TC_PWDN_UP;
        if (!pwr_req)                  state_d = S_OFF;
        else if (cnt_q == TC_PWDN_UP)  state_d = S_UP_RST;
      end
      S_UP_RST: begin
        cnt_term = TC_RST;
        if (!pwr_req)                  state_d = S_OFF;
        else if (cnt_q == TC_RST)      state_d = S_UP_SETTLE;
      end
      S_UP_SETTLE: begin
        cnt_term = TC_SETTLE;
        if (!pwr_req)                  state_d = S_DN_WAIT;
        else if (cnt_q == TC_SETTLE)   state_d = S_ON;
      end
      S_ON: begin
        if (!pwr_req)                  state_d = S_DN_WAIT;
      end
      S_DN_WAIT: begin
        if (!bus_busy)                 state_d = S_DN_RST;
      end
      S_DN_RST: begin
        cnt_term = TC_RST_DN;
        if (cnt_q == TC_RST_DN)        state_d = S_OFF;
      end
      default: begin
        state_d = S_OFF;
      end
    endcase

    if (state_d != state_q)     cnt_d = '0;
    else if (cnt_q < cnt_term)  cnt_d = cnt_q + CNT_W'(1);

    case (state_d)
      S_OFF: begin
        pwr_off_d = (cnt_d == TC_OFF);
      end
      S_UP_RST, S_DN_RST: begin
        pwdn_d = 1'b0;
      end
      S_UP_SETTLE, S_DN_WAIT: begin
        pwdn_d = 1'b0;
        rstb_d = 1'b1;
      end
      S_ON: begin
        pwdn_d   = 1'b0;
        rstb_d   = 1'b1;
        pwr_on_d = 1'b1;
      end
      default: begin
        pwdn_d = 1'b1;
      end
    endcase
  end

endmodule
